// File: rtl/ysyx_22040895_csr_file.sv
// Machine-mode CSR file.
//
// Implements mstatus, mtvec, mscratch, mepc, mcause, mcycle and minstret.
// All of them are 64 bits wide, and mtvec and mepc always hold a
// 4-byte-aligned value because only direct mode is supported.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   privileged_op_i     - 001 ecall, 010 mret, 011 csrrs, 100 csrrw, else none
//   csr_addr_i          - address for the generic read/write port
//   csr_wen_i           - generic write enable, honoured only for 011/100
//   csrwdata_i          - generic write data, already combined by the core
//   csrrdata_o          - generic read data, 0 for unimplemented addresses
//   wdata_mepc_i        - trap PC, captured on ecall
//   wdata_mcause_i      - trap cause, captured on ecall
//   wdata_mstatus_i     - restored mstatus, captured on mret
//   rdata_*_o           - direct combinational views of the trap CSRs
//   instret_i           - one pulse per retired instruction
//   illegal_csr_o       - csrrs/csrrw aimed at an unimplemented address
//
// Reads are combinational from the current register state, so a read in the
// same cycle as a write returns the old value. There is no handshake: every
// input is sampled on each rising edge and takes effect at that edge.
module ysyx_22040895_csr_file #(
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
  parameter logic [63:0] MTVEC_RST   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  privileged_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_wen_i,
  input  logic [63:0] csrwdata_i,
  output logic [63:0] csrrdata_o,
  input  logic [63:0] wdata_mepc_i,
  input  logic [63:0] wdata_mcause_i,
  input  logic [63:0] wdata_mstatus_i,
  output logic [63:0] rdata_mepc_o,
  output logic [63:0] rdata_mcause_o,
  output logic [63:0] rdata_mtvec_o,
  output logic [63:0] rdata_mstatus_o,
  input  logic        instret_i,
  output logic        illegal_csr_o
);

  localparam logic [2:0] OP_ECALL = 3'b001;
  localparam logic [2:0] OP_MRET  = 3'b010;
  localparam logic [2:0] OP_CSRRS = 3'b011;
  localparam logic [2:0] OP_CSRRW = 3'b100;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic [63:0] mstatus, mtvec, mscratch, mepc, mcause, mcycle, minstret;
  logic        csr_op;
  logic        gen_wr;
  logic        implemented;
  logic [63:0] rdata;
  logic [63:0] mstatus_trap;

  assign csr_op = (privileged_op_i == OP_CSRRS) || (privileged_op_i == OP_CSRRW);
  assign gen_wr = csr_op && csr_wen_i;

  // Address decode and read mux. An unimplemented address reads as zero.
  always_comb begin
    rdata       = 64'h0;
    implemented = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:  rdata = mstatus;
      A_MTVEC:    rdata = mtvec;
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = mepc;
      A_MCAUSE:   rdata = mcause;
      A_MCYCLE:   rdata = mcycle;
      A_MINSTRET: rdata = minstret;
      default:    implemented = 1'b0;
    endcase
  end

  // mstatus on trap entry: MPIE takes MIE, MIE is cleared, MPP becomes M-mode.
  always_comb begin
    mstatus_trap        = mstatus;
    mstatus_trap[7]     = mstatus[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
  end

  assign csrrdata_o      = rdata;
  assign illegal_csr_o   = csr_op && !implemented;
  assign rdata_mepc_o    = mepc;
  assign rdata_mcause_o  = mcause;
  assign rdata_mtvec_o   = mtvec;
  assign rdata_mstatus_o = mstatus;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= MTVEC_RST;
      mscratch <= 64'h0;
      mepc     <= 64'h0;
      mcause   <= 64'h0;
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      // Counters advance by default. A software write later in this block
      // overrides the increment.
      mcycle <= mcycle + 64'd1;
      if (instret_i) minstret <= minstret + 64'd1;

      // The op codes are mutually exclusive, so trap updates and generic
      // writes never target a register in the same cycle.
      case (privileged_op_i)
        OP_ECALL: begin
          mepc    <= {wdata_mepc_i[63:2], 2'b00};
          mcause  <= wdata_mcause_i;
          mstatus <= mstatus_trap;
        end
        OP_MRET: mstatus <= wdata_mstatus_i;
        default: begin
          if (gen_wr) begin
            case (csr_addr_i)
              A_MSTATUS:  mstatus  <= csrwdata_i;
              A_MTVEC:    mtvec    <= {csrwdata_i[63:2], 2'b00};
              A_MSCRATCH: mscratch <= csrwdata_i;
              A_MEPC:     mepc     <= {csrwdata_i[63:2], 2'b00};
              A_MCAUSE:   mcause   <= csrwdata_i;
              A_MCYCLE:   mcycle   <= csrwdata_i;
              A_MINSTRET: minstret <= csrwdata_i;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_csr_file.sv
// Testbench for ysyx_22040895_csr_file.
//
// The first phase applies a table of directed vectors. Each vector is held
// for one clock edge, and then the named CSR is read back through the
// generic port and compared with a fixed expected value.
//
// The second phase applies random vectors.
//
// In both phases a reference model tracks the CSRs as an associative array
// keyed by address. Before every edge the combinational outputs are compared
// with that model.
module tb_ysyx_22040895_csr_file;

  logic        clk;
  logic        rst;
  logic [2:0]  privileged_op_i;
  logic [11:0] csr_addr_i;
  logic        csr_wen_i;
  logic [63:0] csrwdata_i;
  logic [63:0] csrrdata_o;
  logic [63:0] wdata_mepc_i, wdata_mcause_i, wdata_mstatus_i;
  logic [63:0] rdata_mepc_o, rdata_mcause_o, rdata_mtvec_o, rdata_mstatus_o;
  logic        instret_i;
  logic        illegal_csr_o;

  localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;

  ysyx_22040895_csr_file dut (
    .clk             (clk),
    .rst             (rst),
    .privileged_op_i (privileged_op_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wen_i       (csr_wen_i),
    .csrwdata_i      (csrwdata_i),
    .csrrdata_o      (csrrdata_o),
    .wdata_mepc_i    (wdata_mepc_i),
    .wdata_mcause_i  (wdata_mcause_i),
    .wdata_mstatus_i (wdata_mstatus_i),
    .rdata_mepc_o    (rdata_mepc_o),
    .rdata_mcause_o  (rdata_mcause_o),
    .rdata_mtvec_o   (rdata_mtvec_o),
    .rdata_mstatus_o (rdata_mstatus_o),
    .instret_i       (instret_i),
    .illegal_csr_o   (illegal_csr_o)
  );

  // Clock and reset block. Reset itself is driven through the vectors.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic [11:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] w_mepc;
    logic [63:0] w_mcause;
    logic [63:0] w_mstatus;
    logic        instret;
    logic        exp_illegal;
    logic [11:0] chk_addr;
    logic [63:0] exp_val;
  } vec_t;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: CSR contents keyed by address.
  logic [63:0] csr [logic [11:0]];
  bit          model_valid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    return csr.exists(a) ? csr[a] : 64'h0;
  endfunction

  // Advance the model by one rising edge under vector v.
  task automatic model_edge(input vec_t v);
    logic [63:0] nxt [logic [11:0]];
    logic [63:0] st;
    if (v.rst) begin
      csr.delete();
      csr[12'h300] = MST_RST;
      csr[12'h305] = 64'h0;
      csr[12'h340] = 64'h0;
      csr[12'h341] = 64'h0;
      csr[12'h342] = 64'h0;
      csr[12'hB00] = 64'h0;
      csr[12'hB02] = 64'h0;
      model_valid = 1;
      return;
    end
    nxt = csr;
    nxt[12'hB00] = csr[12'hB00] + 64'd1;
    if (v.instret) nxt[12'hB02] = csr[12'hB02] + 64'd1;
    case (v.op)
      3'd1: begin
        nxt[12'h341] = v.w_mepc & ~64'd3;
        nxt[12'h342] = v.w_mcause;
        st = csr[12'h300];
        st[7] = st[3];
        st[3] = 1'b0;
        st[12:11] = 2'b11;
        nxt[12'h300] = st;
      end
      3'd2: nxt[12'h300] = v.w_mstatus;
      3'd3, 3'd4: begin
        if (v.wen && csr.exists(v.addr)) begin
          if (v.addr == 12'h305 || v.addr == 12'h341) nxt[v.addr] = v.wdata & ~64'd3;
          else nxt[v.addr] = v.wdata;
        end
      end
      default: ;
    endcase
    csr = nxt;
  endtask

  // Driver: apply one vector, compare the combinational outputs with the
  // model, take one edge and update the model.
  task automatic step(input vec_t v);
    logic exp_ill;
    rst             = v.rst;
    privileged_op_i = v.op;
    csr_addr_i      = v.addr;
    csr_wen_i       = v.wen;
    csrwdata_i      = v.wdata;
    wdata_mepc_i    = v.w_mepc;
    wdata_mcause_i  = v.w_mcause;
    wdata_mstatus_i = v.w_mstatus;
    instret_i       = v.instret;
    #1;
    exp_ill = (v.op == 3'd3 || v.op == 3'd4) && !csr.exists(v.addr);
    if (model_valid) begin
      check("illegal", {63'h0, illegal_csr_o}, {63'h0, exp_ill});
      check("csrrdata", csrrdata_o, m_read(v.addr));
      check("mstatus_view", rdata_mstatus_o, csr[12'h300]);
      check("mtvec_view", rdata_mtvec_o, csr[12'h305]);
      check("mepc_view", rdata_mepc_o, csr[12'h341]);
      check("mcause_view", rdata_mcause_o, csr[12'h342]);
    end
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [11:0] a,
                              input logic w, input logic [63:0] wd, input logic [63:0] me,
                              input logic [63:0] mc, input logic [63:0] ms, input logic ir,
                              input logic ill, input logic [11:0] ca, input logic [63:0] ev);
    vec_t v;
    v.rst = r; v.op = op; v.addr = a; v.wen = w; v.wdata = wd;
    v.w_mepc = me; v.w_mcause = mc; v.w_mstatus = ms; v.instret = ir;
    v.exp_illegal = ill; v.chk_addr = ca; v.exp_val = ev;
    return v;
  endfunction

  vec_t tbl [20];
  logic [11:0] addr_pool [10];

  initial begin
    vec_t v;
    rst = 1'b1; privileged_op_i = 3'd0; csr_addr_i = 12'h0; csr_wen_i = 1'b0;
    csrwdata_i = 64'h0; wdata_mepc_i = 64'h0; wdata_mcause_i = 64'h0;
    wdata_mstatus_i = 64'h0; instret_i = 1'b0;

    //          rst op    addr     wen wdata                   mepc_w          mcause_w  mstatus_w  ir ill chk      expected
    tbl[0]  = mk(1, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'hB00, 64'h0);
    tbl[1]  = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'hB00, 64'h1);
    tbl[2]  = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'hB00, 64'h2);
    tbl[3]  = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'h300, MST_RST);
    tbl[4]  = mk(0, 3'd4, 12'h305, 1, 64'h8000_0003,           64'h0,          64'h0,    64'h0,     0, 0, 12'h305, 64'h8000_0000);
    tbl[5]  = mk(0, 3'd4, 12'h300, 1, 64'h0000_000a_0000_1808, 64'h0,          64'h0,    64'h0,     0, 0, 12'h300, 64'h0000_000a_0000_1808);
    tbl[6]  = mk(0, 3'd1, 12'h000, 0, 64'h0,                   64'h8000_0104,  64'd11,   64'h0,     0, 0, 12'h341, 64'h8000_0104);
    tbl[7]  = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'h342, 64'd11);
    tbl[8]  = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'h300, 64'h0000_000a_0000_1880);
    tbl[9]  = mk(0, 3'd4, 12'hB00, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,          64'h0,    64'h0,     0, 0, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tbl[10] = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     0, 0, 12'hB00, 64'h0);
    tbl[11] = mk(0, 3'd3, 12'h7C0, 1, 64'h1234,                64'h0,          64'h0,    64'h0,     0, 1, 12'h7C0, 64'h0);
    tbl[12] = mk(0, 3'd4, 12'h340, 1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,          64'h0,    64'h0,     0, 0, 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    tbl[13] = mk(0, 3'd0, 12'h340, 1, 64'h5,                   64'h0,          64'h0,    64'h0,     0, 0, 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    tbl[14] = mk(1, 3'd2, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'hFFFF,  0, 0, 12'h300, MST_RST);
    tbl[15] = mk(0, 3'd4, 12'h341, 1, 64'h1237,                64'h0,          64'h0,    64'h0,     0, 0, 12'h341, 64'h1234);
    tbl[16] = mk(0, 3'd4, 12'hB02, 1, 64'd100,                 64'h0,          64'h0,    64'h0,     1, 0, 12'hB02, 64'd100);
    tbl[17] = mk(0, 3'd0, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h0,     1, 0, 12'hB02, 64'd101);
    tbl[18] = mk(0, 3'd2, 12'h000, 0, 64'h0,                   64'h0,          64'h0,    64'h88,    0, 0, 12'h300, 64'h88);
    tbl[19] = mk(1, 3'd1, 12'h000, 0, 64'h0,                   64'h8000_0200,  64'd2,    64'h0,     0, 0, 12'h341, 64'h0);

    for (int i = 0; i < 20; i++) begin
      privileged_op_i = tbl[i].op;
      csr_addr_i      = tbl[i].addr;
      #1;
      // Check the illegal flag for the vector's own op and address.
      check($sformatf("tbl%0d_illegal", i), {63'h0, illegal_csr_o}, {63'h0, tbl[i].exp_illegal});
      step(tbl[i]);
      // Read back through the generic port with no op active.
      privileged_op_i = 3'd0;
      csr_wen_i       = 1'b0;
      instret_i       = 1'b0;
      csr_addr_i      = tbl[i].chk_addr;
      #1;
      check($sformatf("tbl%0d_read_%0h", i, tbl[i].chk_addr), csrrdata_o, tbl[i].exp_val);
    end

    addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h340;
    addr_pool[3] = 12'h341; addr_pool[4] = 12'h342; addr_pool[5] = 12'hB00;
    addr_pool[6] = 12'hB02; addr_pool[7] = 12'h7C0; addr_pool[8] = 12'h301;
    addr_pool[9] = 12'hB01;

    // Random phase, checked against the model before every edge.
    for (int i = 0; i < 400; i++) begin
      v.rst       = ($urandom_range(0, 39) == 0);
      v.op        = 3'($urandom_range(0, 7));
      v.addr      = addr_pool[$urandom_range(0, 9)];
      v.wen       = 1'($urandom_range(0, 1));
      v.wdata     = {$urandom, $urandom};
      v.w_mepc    = {$urandom, $urandom};
      v.w_mcause  = {$urandom, $urandom};
      v.w_mstatus = {$urandom, $urandom};
      v.instret   = 1'($urandom_range(0, 1));
      v.exp_illegal = 1'b0;
      v.chk_addr  = 12'h0;
      v.exp_val   = 64'h0;
      // Occasionally preload the counters near their wrap point.
      if ($urandom_range(0, 29) == 0) begin
        v.op = 3'd4; v.wen = 1'b1;
        v.addr = ($urandom_range(0, 1) == 0) ? 12'hB00 : 12'hB02;
        v.wdata = 64'hFFFF_FFFF_FFFF_FFFE;
      end
      step(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
